// File: rtl/alu_pkg.sv
// Shared definitions for the RV32IM ALU and its decoder: the one-hot
// operation bit indices, vector width and divide special-case constants.
package alu_pkg;

  localparam int INSTR_W = 47;
  localparam int OP_W    = 6;

  typedef logic [OP_W-1:0] opIdx_t;

  // R-type
  localparam opIdx_t OP_ADD    = 6'd0;
  localparam opIdx_t OP_SUB    = 6'd1;
  localparam opIdx_t OP_SLL    = 6'd2;
  localparam opIdx_t OP_SLT    = 6'd3;
  localparam opIdx_t OP_SLTU   = 6'd4;
  localparam opIdx_t OP_XOR    = 6'd5;
  localparam opIdx_t OP_SRL    = 6'd6;
  localparam opIdx_t OP_SRA    = 6'd7;
  localparam opIdx_t OP_OR     = 6'd8;
  localparam opIdx_t OP_AND    = 6'd9;
  // I-type
  localparam opIdx_t OP_ADDI   = 6'd10;
  localparam opIdx_t OP_SLTI   = 6'd11;
  localparam opIdx_t OP_SLTIU  = 6'd12;
  localparam opIdx_t OP_XORI   = 6'd13;
  localparam opIdx_t OP_ORI    = 6'd14;
  localparam opIdx_t OP_ANDI   = 6'd15;
  localparam opIdx_t OP_SLLI   = 6'd16;
  localparam opIdx_t OP_SRLI   = 6'd17;
  localparam opIdx_t OP_SRAI   = 6'd18;
  // Upper immediates and jumps
  localparam opIdx_t OP_LUI    = 6'd19;
  localparam opIdx_t OP_AUIPC  = 6'd20;
  localparam opIdx_t OP_JAL    = 6'd21;
  localparam opIdx_t OP_JALR   = 6'd22;
  // Loads and stores
  localparam opIdx_t OP_LB     = 6'd23;
  localparam opIdx_t OP_LH     = 6'd24;
  localparam opIdx_t OP_LW     = 6'd25;
  localparam opIdx_t OP_LBU    = 6'd26;
  localparam opIdx_t OP_LHU    = 6'd27;
  localparam opIdx_t OP_SB     = 6'd28;
  localparam opIdx_t OP_SH     = 6'd29;
  localparam opIdx_t OP_SW     = 6'd30;
  // Branches
  localparam opIdx_t OP_BEQ    = 6'd31;
  localparam opIdx_t OP_BNE    = 6'd32;
  localparam opIdx_t OP_BLT    = 6'd33;
  localparam opIdx_t OP_BGE    = 6'd34;
  localparam opIdx_t OP_BLTU   = 6'd35;
  localparam opIdx_t OP_BGEU   = 6'd36;
  // System
  localparam opIdx_t OP_FENCE  = 6'd37;
  localparam opIdx_t OP_ECALL  = 6'd38;
  // M-extension
  localparam opIdx_t OP_REMU   = 6'd39;
  localparam opIdx_t OP_MUL    = 6'd40;
  localparam opIdx_t OP_MULH   = 6'd41;
  localparam opIdx_t OP_MULHSU = 6'd42;
  localparam opIdx_t OP_MULHU  = 6'd43;
  localparam opIdx_t OP_DIV    = 6'd44;
  localparam opIdx_t OP_DIVU   = 6'd45;
  localparam opIdx_t OP_REM    = 6'd46;

  localparam logic [31:0] DIV_BY_ZERO = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;

endpackage

// File: rtl/alu_if.sv
// Operand/operation bus between the operand-select stage and the ALU.
interface alu_if;
  import alu_pkg::*;

  logic [31:0]        v1;
  logic [31:0]        v2;
  logic [INSTR_W-1:0] instructions;
  logic [31:0]        ALUoutput;

  modport master (output v1, output v2, output instructions, input ALUoutput);
  modport slave  (input v1, input v2, input instructions, output ALUoutput);

endinterface

// File: rtl/alu_divider.sv
// Combinational 32-bit signed/unsigned divide and remainder following the
// RISC-V divide-by-zero and signed-overflow rules. Used only with ALU_MEXT_EN.
module alu_divider
  import alu_pkg::*;
(
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotS_o,
  output logic [31:0] remS_o,
  output logic [31:0] quotU_o,
  output logic [31:0] remU_o
);

  logic divZero;
  logic overflow;

  assign divZero  = (divisor_i == 32'd0);
  assign overflow = (dividend_i == INT_MIN) && (divisor_i == 32'hFFFF_FFFF);

  // The special cases are resolved here so the real divide never sees a zero divisor
  always_comb begin
    quotS_o = DIV_BY_ZERO;
    remS_o  = dividend_i;
    quotU_o = DIV_BY_ZERO;
    remU_o  = dividend_i;
    if (!divZero) begin
      quotU_o = dividend_i / divisor_i;
      remU_o  = dividend_i % divisor_i;
      if (overflow) begin
        quotS_o = INT_MIN;
        remS_o  = 32'd0;
      end else begin
        quotS_o = $signed(dividend_i) / $signed(divisor_i);
        remS_o  = $signed(dividend_i) % $signed(divisor_i);
      end
    end
  end

endmodule

// File: rtl/alu.sv
// RV32IM integer execution unit: one-hot operation select, registered result.
// Define ALU_MEXT_EN to include the multiplier/divider (bits 39-46).
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [31:0] result_d;
  logic [31:0] result_q;
  opIdx_t      selIdx;
  logic        selValid;

  assign a     = bus.v1;
  assign b     = bus.v2;
  assign shamt = bus.v2[4:0];

`ifdef ALU_MEXT_EN
  logic [31:0] quotS;
  logic [31:0] remS;
  logic [31:0] quotU;
  logic [31:0] remU;

  alu_divider uDivider (
    .dividend_i (a),
    .divisor_i  (b),
    .quotS_o    (quotS),
    .remS_o     (remS),
    .quotU_o    (quotU),
    .remU_o     (remU)
  );
`endif

  // Fixed priority: scanning downwards leaves the lowest set bit selected
  always_comb begin
    selIdx   = '0;
    selValid = 1'b0;
    for (int i = INSTR_W - 1; i >= 0; i--) begin
      if (bus.instructions[i]) begin
        selIdx   = opIdx_t'(i);
        selValid = 1'b1;
      end
    end
  end

  always_comb begin
    result_d = 32'd0;
    if (selValid) begin
      case (selIdx)
        OP_ADD, OP_ADDI:                 result_d = a + b;
        OP_SUB:                          result_d = a - b;
        OP_SLL, OP_SLLI:                 result_d = a << shamt;
        OP_SLT, OP_SLTI:                 result_d = {31'd0, $signed(a) < $signed(b)};
        OP_SLTU, OP_SLTIU:               result_d = {31'd0, a < b};
        OP_XOR, OP_XORI:                 result_d = a ^ b;
        OP_SRL, OP_SRLI:                 result_d = a >> shamt;
        OP_SRA, OP_SRAI:                 result_d = $signed(a) >>> shamt;
        OP_OR, OP_ORI:                   result_d = a | b;
        OP_AND, OP_ANDI:                 result_d = a & b;
        OP_LUI:                          result_d = b;
        OP_AUIPC:                        result_d = a + b;
        OP_JAL, OP_JALR:                 result_d = a + 32'd4;
        OP_LB, OP_LH, OP_LW, OP_LBU,
        OP_LHU, OP_SB, OP_SH, OP_SW:     result_d = a + b;
        OP_BEQ:                          result_d = {31'd0, a == b};
        OP_BNE:                          result_d = {31'd0, a != b};
        OP_BLT:                          result_d = {31'd0, $signed(a) < $signed(b)};
        OP_BGE:                          result_d = {31'd0, $signed(a) >= $signed(b)};
        OP_BLTU:                         result_d = {31'd0, a < b};
        OP_BGEU:                         result_d = {31'd0, a >= b};
        OP_FENCE, OP_ECALL:              result_d = 32'd0;
`ifdef ALU_MEXT_EN
        OP_REMU:   result_d = remU;
        OP_MUL:    result_d = a * b;
        // High halves come from a 64-bit product of the suitably extended operands
        OP_MULH:   result_d = 32'(({{32{a[31]}}, a} * {{32{b[31]}}, b}) >> 32);
        OP_MULHSU: result_d = 32'(({{32{a[31]}}, a} * {32'd0, b}) >> 32);
        OP_MULHU:  result_d = 32'(({32'd0, a} * {32'd0, b}) >> 32);
        OP_DIV:    result_d = quotS;
        OP_DIVU:   result_d = quotU;
        OP_REM:    result_d = remS;
`endif
        default:                         result_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 32'd0;
    end else begin
      result_q <= result_d;
    end
  end

  assign bus.ALUoutput = result_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus randomized
// operations checked against a behavioural model (honours ALU_MEXT_EN).
module tb_alu;
  import alu_pkg::*;

`ifdef ALU_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [46:0] oneHot(input int k);
    return 47'(1) << k;
  endfunction

  // Reference model computed straight from the operation table with wide integers
  function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [46:0] ops);
    int k = -1;
    longint sa;
    longint sb;
    longint unsigned ua;
    longint unsigned ub;
    longint p;
    int sh;
    for (int i = 0; i < 47; i++) if (ops[i] && k < 0) k = i;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    sh = int'(b[4:0]);
    if (k >= 39 && !MEXT) return 32'd0;
    case (k)
      0, 10, 20:           return a + b;
      1:                   return a - b;
      2, 16:               return 32'(ua << sh);
      3, 11, 33:           return (sa < sb) ? 32'd1 : 32'd0;
      4, 12, 35:           return (ua < ub) ? 32'd1 : 32'd0;
      5, 13:               return a ^ b;
      6, 17:               return 32'(ua >> sh);
      7, 18:               return 32'(sa >>> sh);
      8, 14:               return a | b;
      9, 15:               return a & b;
      19:                  return b;
      21, 22:              return a + 32'd4;
      23, 24, 25, 26, 27, 28, 29, 30: return a + b;
      31:                  return (a == b) ? 32'd1 : 32'd0;
      32:                  return (a != b) ? 32'd1 : 32'd0;
      34:                  return (sa >= sb) ? 32'd1 : 32'd0;
      36:                  return (ua >= ub) ? 32'd1 : 32'd0;
      39:                  return (b == 0) ? a : 32'(ua % ub);
      40:                  return 32'(sa * sb);
      41:                  begin p = sa * sb;          return 32'(p >>> 32); end
      42:                  begin p = sa * longint'(ua); return 32'(p >>> 32); end
      43:                  return 32'((ua * ub) >> 32);
      44:                  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      45:                  return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      46:                  return (b == 0) ? a : 32'(sa % sb);
      default:             return 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [46:0] ops);
    @(negedge clk);
    bus.v1           = a;
    bus.v2           = b;
    bus.instructions = ops;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 31));
      default: return 32'($urandom);
    endcase
  endfunction

  logic [31:0] expR [10] = '{32'd9, 32'd1, 32'd80, 32'd0, 32'd0,
                              32'd1, 32'd0, 32'd0, 32'd5, 32'd4};
  logic [31:0] expM [8]  = '{32'd1, 32'd20, 32'd0, 32'd0,
                              32'd0, 32'd1, 32'd1, 32'd1};

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [46:0] rops;
    logic [63:0] rbits;
    int          k;

    bus.v1           = 32'd0;
    bus.v2           = 32'd0;
    bus.instructions = '0;

    // Reset, asynchronous and held across edges
    #1 rst = 1'b1;
    #1 checkOutput("reset_async", bus.ALUoutput, 32'd0);
    repeat (2) @(posedge clk);
    #1 checkOutput("reset_hold", bus.ALUoutput, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Walking R-type ops; the output must hold until the next edge
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.v1           = 32'd5;
      bus.v2           = 32'd4;
      bus.instructions = oneHot(i);
      #1;
      if (i > 0) checkOutput($sformatf("latency%0d", i), bus.ALUoutput, expR[i-1]);
      @(posedge clk);
      #1 checkOutput($sformatf("rtype%0d", i), bus.ALUoutput, expR[i]);
    end

    // M-extension with small operands
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'd5, 32'd4, oneHot(39 + i));
      checkOutput($sformatf("mext%0d", 39 + i), bus.ALUoutput, MEXT ? expM[i] : 32'd0);
    end

    // Divide overflow and divide by zero
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, oneHot(44));
    checkOutput("div_ovf", bus.ALUoutput, MEXT ? 32'h8000_0000 : 32'd0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, oneHot(46));
    checkOutput("rem_ovf", bus.ALUoutput, 32'd0);
    applyStimulus(32'h8000_0000, 32'd0, oneHot(45));
    checkOutput("divu_zero", bus.ALUoutput, MEXT ? 32'hFFFF_FFFF : 32'd0);
    applyStimulus(32'h8000_0000, 32'd0, oneHot(39));
    checkOutput("remu_zero", bus.ALUoutput, MEXT ? 32'h8000_0000 : 32'd0);

    // Negative operand shifts and compares, multi-hot priority, empty select
    applyStimulus(32'hFFFF_FFF0, 32'd4, oneHot(7));
    checkOutput("sra_neg", bus.ALUoutput, 32'hFFFF_FFFF);
    applyStimulus(32'hFFFF_FFF0, 32'd4, oneHot(6));
    checkOutput("srl_neg", bus.ALUoutput, 32'h0FFF_FFFF);
    applyStimulus(32'hFFFF_FFF0, 32'd4, oneHot(3));
    checkOutput("slt_neg", bus.ALUoutput, 32'd1);
    applyStimulus(32'hFFFF_FFF0, 32'd4, oneHot(4));
    checkOutput("sltu_neg", bus.ALUoutput, 32'd0);
    applyStimulus(32'hFFFF_FFF0, 32'd4, oneHot(0) | oneHot(1));
    checkOutput("multihot", bus.ALUoutput, 32'hFFFF_FFF4);
    applyStimulus(32'hFFFF_FFF0, 32'd4, '0);
    checkOutput("all_zero", bus.ALUoutput, 32'd0);
    applyStimulus(32'h1000_0000, 32'd8, oneHot(21));
    checkOutput("jal_link", bus.ALUoutput, 32'h1000_0004);

    // Asynchronous reset between edges while the output shows 9
    applyStimulus(32'd5, 32'd4, oneHot(0));
    checkOutput("pre_reset", bus.ALUoutput, 32'd9);
    #2 rst = 1'b1;
    #1 checkOutput("reset_midcycle", bus.ALUoutput, 32'd0);
    @(posedge clk);
    #1 checkOutput("reset_midhold", bus.ALUoutput, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 checkOutput("post_reset", bus.ALUoutput, 32'd9);

    // Randomized operations against the reference model
    for (int n = 0; n < 400; n++) begin
      ra = pickOperand();
      rb = pickOperand();
      k  = int'($urandom_range(0, 46));
      case ($urandom_range(0, 9))
        0: rops = '0;
        1, 2: begin
          rbits = {$urandom, $urandom};
          rops  = oneHot(k) | (rbits[46:0] << k);
        end
        default: rops = oneHot(k);
      endcase
      applyStimulus(ra, rb, rops);
      checkOutput($sformatf("rand%0d_op%0d", n, k), bus.ALUoutput, refAlu(ra, rb, rops));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
